usb_tx_serializer: RTL and testbench

USB_TX_SERIALIZER -- requirements
Module: usb_tx_serializer

---
 rtl/usb_tx_serializer.sv | 235 +++++++++++++++++++++++
 tb/tb_usb_tx_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_serializer.sv
// USB full-speed transmit serializer: SYNC, NRZI data with bit stuffing, EOP.
// Ports:
//   clk48, rst (sync, active-high)
//   txReqSend                          start request, sampled in IDLE only
//   txData/txDataValid/txIsLastByte    byte source, consumed on txAcceptNewData
//   txAcceptNewData                    one-cycle fetch strobe per byte
//   txIsSending                        packet in progress
//   dataOutP_reg/dataOutN_reg          registered D+/D- drive values
//   outEn_reg                          registered output enable
module usb_tx_serializer #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic       clk48,
    input  logic       rst,
    input  logic       txReqSend,
    input  logic [7:0] txData,
    input  logic       txDataValid,
    input  logic       txIsLastByte,
    output logic       txAcceptNewData,
    output logic       txIsSending,
    output logic       dataOutP_reg,
    output logic       dataOutN_reg,
    output logic       outEn_reg
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic          stuff_q, stuff_d;
    logic [2:0]    ones_q, ones_d;
    logic          nrzi_q, nrzi_d;
    logic          curLast_q, curLast_d;
    logic [7:0]    nxt_q, nxt_d;
    logic          nxtLast_q, nxtLast_d;
    logic          nxtValid_q, nxtValid_d;
    logic          p_q, p_d;
    logic          n_q, n_d;
    logic          oe_q, oe_d;

    logic       symEnd;
    logic       active;
    logic       fetch;
    logic       fetchTake;
    logic       nxtAvail;
    logic [7:0] nxtByte;
    logic       nxtLastB;
    logic [2:0] nextIdx;
    logic       sendBit;
    logic       bitVal;

    assign symEnd    = (cnt_q == CNT_MAX);
    assign active    = (state_q == SYNC) || (state_q == DATA);
    // Fetch strobe: first cycle of bit 7 of a non-final byte (never a stuff bit)
    assign fetch     = active && (cnt_q == '0) && (bitIdx_q == 3'd7)
                       && !stuff_q && !curLast_q;
    assign fetchTake = fetch && txDataValid;
    // Bypass lets a byte fetched this cycle be loaded this cycle when
    // a symbol is only one clock long.
    assign nxtAvail  = nxtValid_q || fetchTake;
    assign nxtByte   = fetchTake ? txData : nxt_q;
    assign nxtLastB  = fetchTake ? txIsLastByte : nxtLast_q;
    assign nextIdx   = bitIdx_q + 3'd1;

    always_ff @(posedge clk48) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            bitIdx_q   <= '0;
            stuff_q    <= 1'b0;
            ones_q     <= '0;
            nrzi_q     <= 1'b1;
            curLast_q  <= 1'b0;
            nxt_q      <= '0;
            nxtLast_q  <= 1'b0;
            nxtValid_q <= 1'b0;
            p_q        <= 1'b1;
            n_q        <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bitIdx_q   <= bitIdx_d;
            stuff_q    <= stuff_d;
            ones_q     <= ones_d;
            nrzi_q     <= nrzi_d;
            curLast_q  <= curLast_d;
            nxt_q      <= nxt_d;
            nxtLast_q  <= nxtLast_d;
            nxtValid_q <= nxtValid_d;
            p_q        <= p_d;
            n_q        <= n_d;
            oe_q       <= oe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        bitIdx_d   = bitIdx_q;
        stuff_d    = stuff_q;
        ones_d     = ones_q;
        nrzi_d     = nrzi_q;
        curLast_d  = curLast_q;
        nxt_d      = nxt_q;
        nxtLast_d  = nxtLast_q;
        nxtValid_d = nxtValid_q;
        p_d        = p_q;
        n_d        = n_q;
        oe_d       = oe_q;
        sendBit    = 1'b0;
        bitVal     = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = symEnd ? '0 : cnt_q + CW'(1);
        end

        if (fetchTake) begin
            nxt_d      = txData;
            nxtLast_d  = txIsLastByte;
            nxtValid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (txReqSend) begin
                    state_d    = SYNC;
                    cnt_d      = '0;
                    shift_d    = 8'h80;
                    bitIdx_d   = 3'd0;
                    stuff_d    = 1'b0;
                    ones_d     = 3'd0;
                    curLast_d  = 1'b0;
                    nxtValid_d = 1'b0;
                    oe_d       = 1'b1;
                    sendBit    = 1'b1;
                    bitVal     = 1'b0;
                end
            end
            SYNC, DATA: begin
                if (symEnd) begin
                    if (ones_q == 3'd6) begin
                        // Stuffed zero: toggle without advancing the byte
                        nrzi_d  = ~nrzi_q;
                        ones_d  = 3'd0;
                        stuff_d = 1'b1;
                        p_d     = ~nrzi_q;
                        n_d     = nrzi_q;
                    end else if (bitIdx_q != 3'd7) begin
                        bitIdx_d = nextIdx;
                        stuff_d  = 1'b0;
                        sendBit  = 1'b1;
                        bitVal   = shift_q[nextIdx];
                    end else if (nxtAvail) begin
                        state_d    = DATA;
                        shift_d    = nxtByte;
                        bitIdx_d   = 3'd0;
                        curLast_d  = nxtLastB;
                        nxtValid_d = 1'b0;
                        stuff_d    = 1'b0;
                        sendBit    = 1'b1;
                        bitVal     = nxtByte[0];
                    end else begin
                        // Last byte done or source ran dry
                        state_d  = EOP_SE0;
                        bitIdx_d = 3'd0;
                        stuff_d  = 1'b0;
                        p_d      = 1'b0;
                        n_d      = 1'b0;
                    end
                end
            end
            EOP_SE0: begin
                if (symEnd) begin
                    if (bitIdx_q == 3'd0) begin
                        bitIdx_d = 3'd1;
                    end else begin
                        state_d = EOP_J;
                        p_d     = 1'b1;
                        n_d     = 1'b0;
                    end
                end
            end
            EOP_J: begin
                if (symEnd) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    bitIdx_d   = 3'd0;
                    ones_d     = 3'd0;
                    nrzi_d     = 1'b1;
                    nxtValid_d = 1'b0;
                    oe_d       = 1'b0;
                    p_d        = 1'b1;
                    n_d        = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // NRZI: zero toggles the line, one holds it and counts toward a stuff
        if (sendBit) begin
            if (bitVal) begin
                ones_d = ones_q + 3'd1;
            end else begin
                nrzi_d = ~nrzi_q;
                ones_d = 3'd0;
            end
            p_d = nrzi_d;
            n_d = ~nrzi_d;
        end
    end

    assign txAcceptNewData = fetch;
    assign txIsSending     = (state_q != IDLE);
    assign dataOutP_reg    = p_q;
    assign dataOutN_reg    = n_q;
    assign outEn_reg       = oe_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer.
// Scoreboard of per-cycle line vectors built from a reference encoder.
module tb_usb_tx_serializer;

    localparam int CPB = 4;

    logic       clk48;
    logic       rst;
    logic       txReqSend;
    logic [7:0] txData;
    logic       txDataValid;
    logic       txIsLastByte;
    logic       txAcceptNewData;
    logic       txIsSending;
    logic       dataOutP_reg;
    logic       dataOutN_reg;
    logic       outEn_reg;

    usb_tx_serializer #(.CLK_PER_BIT(CPB)) dut (
        .clk48           (clk48),
        .rst             (rst),
        .txReqSend       (txReqSend),
        .txData          (txData),
        .txDataValid     (txDataValid),
        .txIsLastByte    (txIsLastByte),
        .txAcceptNewData (txAcceptNewData),
        .txIsSending     (txIsSending),
        .dataOutP_reg    (dataOutP_reg),
        .dataOutN_reg    (dataOutN_reg),
        .outEn_reg       (outEn_reg)
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    // vector = {sending, oe, P, N, accept}
    localparam logic [4:0] IDLE_V = 5'b00100;

    int n_chk  = 0;
    int n_fail = 0;

    logic [8:0] src_q[$];
    logic [4:0] sb_q[$];
    logic       m_nrzi;
    int         m_ones;
    int         acc_exp;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] line_v();
        return {txIsSending, outEn_reg, dataOutP_reg, dataOutN_reg,
                txAcceptNewData};
    endfunction

    task automatic drive_src();
        if (src_q.size() > 0) begin
            txDataValid  = 1'b1;
            txData       = src_q[0][7:0];
            txIsLastByte = src_q[0][8];
        end else begin
            txDataValid  = 1'b0;
            txData       = 8'h00;
            txIsLastByte = 1'b0;
        end
    endtask

    task automatic push_sym(input logic [3:0] s, input logic acc);
        for (int c = 0; c < CPB; c++)
            sb_q.push_back({s, (c == 0) ? acc : 1'b0});
        if (acc) acc_exp++;
    endtask

    task automatic put_bit(input logic b, input logic acc);
        if (!b) begin
            m_nrzi = ~m_nrzi;
            m_ones = 0;
        end else begin
            m_ones++;
        end
        push_sym({2'b11, m_nrzi, ~m_nrzi}, acc);
        if (m_ones == 6) begin
            m_nrzi = ~m_nrzi;
            m_ones = 0;
            push_sym({2'b11, m_nrzi, ~m_nrzi}, 1'b0);
        end
    endtask

    // Build expectation from src_q, request, then compare every cycle.
    // abort_idx >= 0: pulse rst at that cycle. req_idx >= 0: stray request.
    task automatic run_packet(input string tag, input int abort_idx,
                              input int req_idx);
        logic [7:0] sync_b;
        logic [7:0] bv;
        logic       lastf;
        logic [4:0] e;
        logic       pop;
        int         n_exp;
        int         consumed;
        int         pulses;
        int         idx;
        sb_q.delete();
        m_nrzi  = 1'b1;
        m_ones  = 0;
        acc_exp = 0;
        n_exp   = 0;
        sync_b  = 8'h80;
        for (int i = 0; i < 8; i++)
            put_bit(sync_b[i], i == 7);
        for (int k = 0; k < src_q.size(); k++) begin
            bv    = src_q[k][7:0];
            lastf = src_q[k][8];
            for (int i = 0; i < 8; i++)
                put_bit(bv[i], (i == 7) && !lastf);
            n_exp++;
            if (lastf) break;
        end
        push_sym(4'b1100, 1'b0);
        push_sym(4'b1100, 1'b0);
        push_sym(4'b1110, 1'b0);

        drive_src();
        txReqSend = 1'b1;
        @(posedge clk48);
        #1;
        txReqSend = 1'b0;
        consumed = 0;
        pulses   = 0;
        idx      = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk48);
            chk(tag, line_v(), e);
            pop = txAcceptNewData && txDataValid;
            if (txAcceptNewData) pulses++;
            if (idx == abort_idx) begin
                rst = 1'b1;
                @(posedge clk48);
                #1;
                rst = 1'b0;
                @(negedge clk48);
                chk({tag, "_rst"}, line_v(), IDLE_V);
                sb_q.delete();
                src_q.delete();
                drive_src();
                return;
            end
            @(posedge clk48);
            #1;
            if (pop) begin
                void'(src_q.pop_front());
                consumed++;
            end
            txReqSend = (idx == req_idx);
            drive_src();
            idx++;
        end
        txReqSend = 1'b0;
        @(negedge clk48);
        chk({tag, "_idle"}, line_v(), IDLE_V);
        chk({tag, "_consumed"}, consumed, n_exp);
        chk({tag, "_pulses"}, pulses, acc_exp);
        src_q.delete();
        drive_src();
    endtask

    initial begin
        rst          = 1'b1;
        txReqSend    = 1'b0;
        txData       = 8'h00;
        txDataValid  = 1'b0;
        txIsLastByte = 1'b0;
        repeat (3) @(posedge clk48);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk48);
            chk("reset", line_v(), IDLE_V);
        end

        src_q.push_back({1'b1, 8'hA5});
        run_packet("a5", -1, -1);

        src_q.push_back({1'b1, 8'hFF});
        run_packet("ff", -1, -1);

        src_q.push_back({1'b0, 8'h7F});
        src_q.push_back({1'b1, 8'hFF});
        run_packet("7f_ff", -1, -1);

        src_q.push_back({1'b1, 8'h3F});
        run_packet("3f", -1, -1);

        src_q.push_back({1'b1, 8'hFC});
        run_packet("fc_tail", -1, -1);

        src_q.push_back({1'b0, 8'h12});
        run_packet("underflow", -1, -1);

        // DATA bit 3 of 0xA5 starts at cycle 44 (8 SYNC + 3 bits, no stuffing)
        src_q.push_back({1'b1, 8'hA5});
        run_packet("abort", 45, -1);

        src_q.push_back({1'b0, 8'h5A});
        src_q.push_back({1'b1, 8'hC3});
        run_packet("post_rst", -1, 50);

        src_q.push_back({1'b1, 8'h00});
        run_packet("b2b", -1, -1);

        src_q.push_back({1'b0, 8'h01});
        src_q.push_back({1'b0, 8'h80});
        src_q.push_back({1'b1, 8'hFE});
        run_packet("three", -1, 20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
